// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: 4-port AXI-Stream packet arbiter with an 8-bit data path.
// The arbiter grants one requester at a time and holds that grant for a whole
// packet, until the beat carrying tlast is accepted. Each packet is followed by
// one IDLE cycle in which the next winner is chosen. The output is a
// single-entry register stage.
//
// Ports:
//   aclk, aresetn       clock; synchronous active-low reset
//   s_axis_tdata[31:0]  requester data, port n on bits [8n+7:8n]
//   s_axis_tvalid[3:0]  per-port VALID
//   s_axis_tlast[3:0]   per-port LAST
//   s_axis_tready[3:0]  per-port READY (combinational, from registered state)
//   m_axis_tready       downstream READY
//   m_axis_tvalid/tdata/tlast/tid   registered output beat
//   grant[3:0]          registered one-hot grant, zero while IDLE
//   busy                registered, high while a packet is in progress
//
// Build option: define AXIS_ARB_FIXED_PRIO_EN to select fixed priority. In that
// build the lowest-index valid port always wins and the pointer is not used.
// Round-robin is the default.
module axis_rr_arbiter (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tvalid,
  input  logic [3:0]  s_axis_tlast,
  output logic [3:0]  s_axis_tready,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [1:0]  m_axis_tid,
  output logic [3:0]  grant,
  output logic        busy
);

  localparam int unsigned NPORTS = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned IDW    = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IDW-1:0]    win_q, win_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic [DW-1:0]     data_q, data_d;
  logic              last_q, last_d;
  logic [IDW-1:0]    tid_q, tid_d;

  logic              found_c;
  logic [IDW-1:0]    win_c;
  logic [IDW-1:0]    cand_c;
  logic              cap_c;
  logic [DW-1:0]     sel_data_c;

  // The granted port may only push when the output register can take a beat.
  // Reset forces all READY bits low, even before the first reset edge.
  always_comb begin
    s_axis_tready = '0;
    if (aresetn && busy_q && (!full_q || m_axis_tready)) begin
      s_axis_tready = grant_q;
    end
  end

  // Pick the first valid port, starting the search at the pointer.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
`ifdef AXIS_ARB_FIXED_PRIO_EN
      cand_c = IDW'(i);
`else
      cand_c = IDW'(ptr_q + IDW'(i));
`endif
      if (!found_c && s_axis_tvalid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  assign sel_data_c = s_axis_tdata[{win_q, 3'b000} +: DW];
  assign cap_c      = s_axis_tvalid[win_q] && s_axis_tready[win_q];

  // Next-state logic for the FSM and the output register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    win_d   = win_q;
    busy_d  = busy_q;
    full_d  = full_q;
    data_d  = data_q;
    last_d  = last_q;
    tid_d   = tid_q;

    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          state_d = ST_BUSY;
          grant_d = NPORTS'(4'b0001 << win_c);
          win_d   = win_c;
          busy_d  = 1'b1;
        end
      end
      ST_BUSY: begin
        // The grant is released only once the tlast beat has been accepted.
        if (cap_c && s_axis_tlast[win_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
          ptr_d   = IDW'(win_q + IDW'(1));
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // A capture refills the register even when the current beat leaves on the same edge.
    if (cap_c) begin
      full_d = 1'b1;
      data_d = sel_data_c;
      last_d = s_axis_tlast[win_q];
      tid_d  = win_q;
    end else if (m_axis_tready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      win_q   <= '0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      data_q  <= data_d;
      last_q  <= last_d;
      tid_q   <= tid_d;
    end
  end

  assign m_axis_tvalid = full_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tid    = tid_q;
  assign grant         = grant_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Testbench for axis_rr_arbiter. Expected output beats are queued when the
// bench drives each packet. A monitor pops and checks one beat for every
// output handshake.
module tb_axis_rr_arbiter;

  logic        clk;
  logic        aresetn;
  logic [7:0]  pd [4];
  logic [3:0]  pv;
  logic [3:0]  pl;
  logic [31:0] s_tdata;
  logic [3:0]  s_tready;
  logic        m_tready;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic [1:0]  m_tid;
  logic [3:0]  grant;
  logic        busy;

  assign s_tdata = {pd[3], pd[2], pd[1], pd[0]};

  axis_rr_arbiter dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (pv),
    .s_axis_tlast  (pl),
    .s_axis_tready (s_tready),
    .m_axis_tready (m_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .grant         (grant),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entry: {tid[1:0], last, data[7:0]}
  logic [10:0] sb [$];
  bit          arm_first = 1'b0;
  int          first_out_cyc = 0;

  function automatic void push_pkt(input int p, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      sb.push_back({2'(p), (i == len - 1), 8'(int'(base) + i)});
    end
  endfunction

  always @(negedge clk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", {21'd0, m_tid, m_tlast, m_tdata}, 32'h0);
        check_eq("sb_empty_pop", 32'd1, 32'd0);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        check_eq("beat", {21'd0, m_tid, m_tlast, m_tdata}, {21'd0, e});
        if (arm_first) begin
          first_out_cyc = cyc;
          arm_first     = 1'b0;
        end
      end
    end
  end

  // Drive one beat on port p and wait (bounded) for its handshake edge.
  task automatic send_beat(input int p, input logic [7:0] d, input logic l, output int hs_cyc);
    bit ok;
    ok    = 1'b0;
    pd[p] = d;
    pl[p] = l;
    pv[p] = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (s_tready[p]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("handshake_timeout_p%0d", p), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
  endtask

  task automatic send_pkt(input int p, input int len, input logic [7:0] base,
                          output int first_c, output int last_c);
    int hc;
    first_c = 0;
    last_c  = 0;
    for (int i = 0; i < len; i++) begin
      send_beat(p, 8'(int'(base) + i), (i == len - 1), hc);
      if (i == 0) first_c = hc;
      last_c = hc;
    end
    pv[p] = 1'b0;
    pl[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 aresetn = 1'b0;
    @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, l0, f1, l1, start;
    int leak;
    bit done0, ok;
    logic [3:0] got_g [5];
    logic [3:0] exp_g [5];
    logic [3:0] prev_g;
    int k;

    aresetn  = 1'b0;
    m_tready = 1'b1;
    pv       = 4'hF;
    pl       = 4'h0;
    for (int i = 0; i < 4; i++) pd[i] = 8'h00;

    // Reset state, with every port requesting so READY gating is exercised.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_grant",  32'(grant),    32'd0);
    check_eq("rst_busy",   32'(busy),     32'd0);
    check_eq("rst_tdata",  32'(m_tdata),  32'd0);
    check_eq("rst_tlast",  32'(m_tlast),  32'd0);
    check_eq("rst_tid",    32'(m_tid),    32'd0);
    check_eq("rst_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    pv      = 4'h0;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single port 2 packet, with first-output latency and grant timing.
    push_pkt(2, 3, 8'h11);
    sb[0] = {2'd2, 1'b0, 8'h11};
    sb[1] = {2'd2, 1'b0, 8'h22};
    sb[2] = {2'd2, 1'b1, 8'h33};
    start     = cyc;
    arm_first = 1'b1;
    fork
      begin
        int hc;
        send_beat(2, 8'h11, 1'b0, hc);
        send_beat(2, 8'h22, 1'b0, hc);
        send_beat(2, 8'h33, 1'b1, hc);
        pv[2] = 1'b0;
        pl[2] = 1'b0;
      end
      begin
        @(negedge clk);
        check_eq("p2_grant_c",  32'(grant), 32'h0);
        @(negedge clk);
        check_eq("p2_grant_c1", 32'(grant), 32'h4);
        check_eq("p2_busy_c1",  32'(busy),  32'd1);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check_eq("p2_first_latency", 32'(first_out_cyc - start), 32'd2);

    // All ports valid with 1-beat packets, starting from pointer 0.
    do_reset();
`ifdef AXIS_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) exp_g[i] = 4'b0001;
    for (int i = 0; i < 5; i++) push_pkt(0, 1, 8'hA0);
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int i = 0; i < 5; i++) push_pkt(i % 4, 1, 8'(8'hA0 + (i % 4)));
`endif
    for (int i = 0; i < 4; i++) pd[i] = 8'(8'hA0 + i);
    pl     = 4'hF;
    pv     = 4'hF;
    prev_g = 4'h0;
    k      = 0;
    for (int t = 0; t < 60 && k < 5; t++) begin
      @(negedge clk);
      if (grant != 4'h0 && prev_g == 4'h0) begin
        got_g[k] = grant;
        k++;
      end
      prev_g = grant;
    end
    @(posedge clk);
    #1;
    pv = 4'h0;
    pl = 4'h0;
    check_eq("rr_grant_count", 32'(k), 32'd5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("rr_grant_%0d", i), 32'(got_g[i]), 32'(exp_g[i]));
    repeat (4) @(posedge clk);
    #1;

    // Port 1 requests while port 0 is mid-packet; port 1 waits for its turn.
    push_pkt(0, 4, 8'h10);
    push_pkt(1, 2, 8'h20);
    done0 = 1'b0;
    leak  = 0;
    fork
      begin
        send_pkt(0, 4, 8'h10, f0, l0);
        done0 = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        send_pkt(1, 2, 8'h20, f1, l1);
      end
      begin
        for (int t = 0; t < 64 && !done0; t++) begin
          @(negedge clk);
          if (!done0 && s_tready[1]) leak++;
        end
      end
    join
    check_eq("lock_no_leak", 32'(leak), 32'd0);
    check_eq("lock_bubble", 32'(f1 - l0), 32'd2);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: stall the output with a beat held in the register.
    m_tready = 1'b0;
    push_pkt(1, 4, 8'h30);
    fork
      send_pkt(1, 4, 8'h30, f0, l0);
      begin
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
          @(negedge clk);
          if (m_tvalid) begin
            ok = 1'b1;
            break;
          end
        end
        check_eq("bp_valid_seen", 32'(ok), 32'd1);
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_tdata_hold", 32'(m_tdata),     32'h30);
          check_eq("bp_tready_low", 32'(s_tready[1]), 32'd0);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset during the second beat of a port 2 packet.
    m_tready = 1'b0;
    begin
      int hc;
      send_beat(2, 8'h50, 1'b0, hc);
    end
    pd[2] = 8'h51;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    aresetn  = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    check_eq("rst_hold_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    pv      = 4'h0;
    pl      = 4'h0;
    @(negedge clk);
    check_eq("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("midrst_grant",  32'(grant),    32'd0);
    check_eq("midrst_busy",   32'(busy),     32'd0);
    check_eq("midrst_tdata",  32'(m_tdata),  32'd0);
    @(posedge clk);
    #1;

    // After reset the pointer is 0, so port 1 beats port 3 in the search.
    push_pkt(1, 1, 8'h61);
    push_pkt(3, 2, 8'h70);
    fork
      send_pkt(1, 1, 8'h61, f0, l0);
      send_pkt(3, 2, 8'h70, f1, l1);
    join
    repeat (6) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
